// File: rtl/dir_ctl.sv
// rtl/dir_ctl.sv - cache directory sequencer: sweep clear, lookup, fill, invalidate
module dir_ctl #(
  parameter int ROWS = 128,
  parameter int WAYS = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_val,
  output logic        req_rdy,
  input  logic [1:0]  req_op,
  input  logic [6:0]  req_adr,
  input  logic [6:0]  req_tag,
  input  logic [1:0]  req_way,
  output logic        rsp_val,
  output logic [1:0]  rsp_op,
  output logic        rsp_hit,
  output logic [1:0]  rsp_way,
  output logic        busy,
  output logic [6:0]  dir_rd_adr,
  input  logic [31:0] dir_rd_dat,
  output logic [3:0]  dir_wr_en,
  output logic [6:0]  dir_wr_adr,
  output logic [31:0] dir_wr_dat
);

  localparam logic [1:0] OP_LOOKUP = 2'b00;
  localparam logic [1:0] OP_FILL   = 2'b01;
  localparam logic [1:0] OP_INV    = 2'b10;
  localparam logic [1:0] OP_INVALL = 2'b11;
  localparam logic [7:0] ROWS_C    = 8'(ROWS);

  typedef enum logic [2:0] {SWEEP, IDLE, RD, CMP, WR, RSP} state_t;

  state_t          state;
  logic [7:0]      cnt;
  logic            sweep_rsp;
  logic [1:0]      op_q;
  logic [6:0]      adr_q;
  logic [6:0]      tag_q;
  logic [1:0]      way_q;
  logic            hit_q;
  logic [1:0]      hit_way_q;
  logic [WAYS-1:0] hit_vec;
  logic [1:0]      low_way;

  // per-way tag match against the row returned by the RAM
  always_comb begin
    hit_vec = '0;
    for (int w = 0; w < WAYS; w++) begin
      hit_vec[w] = dir_rd_dat[8*w+7] && (dir_rd_dat[8*w +: 7] == tag_q);
    end
  end

  // lowest-index matching way reported on multiple hits
  always_comb begin
    low_way = 2'd0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      if (hit_vec[w]) low_way = 2'(w);
    end
  end

  // sequencer: every output is registered for the state being entered
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= SWEEP;
      cnt        <= 8'd0;
      sweep_rsp  <= 1'b0;
      op_q       <= 2'd0;
      adr_q      <= 7'd0;
      tag_q      <= 7'd0;
      way_q      <= 2'd0;
      hit_q      <= 1'b0;
      hit_way_q  <= 2'd0;
      req_rdy    <= 1'b0;
      rsp_val    <= 1'b0;
      rsp_op     <= 2'd0;
      rsp_hit    <= 1'b0;
      rsp_way    <= 2'd0;
      busy       <= 1'b1;
      dir_rd_adr <= 7'd0;
      dir_wr_en  <= 4'd0;
      dir_wr_adr <= 7'd0;
      dir_wr_dat <= 32'd0;
    end else begin
      rsp_val   <= 1'b0;
      dir_wr_en <= 4'd0;
      case (state)
        SWEEP: begin
          if (cnt == ROWS_C) begin
            state     <= IDLE;
            busy      <= 1'b0;
            req_rdy   <= 1'b1;
            sweep_rsp <= 1'b0;
            if (sweep_rsp) begin
              rsp_val <= 1'b1;
              rsp_op  <= OP_INVALL;
              rsp_hit <= 1'b0;
              rsp_way <= 2'd0;
            end
          end else begin
            dir_wr_en  <= 4'hF;
            dir_wr_adr <= cnt[6:0];
            dir_wr_dat <= 32'd0;
            cnt        <= cnt + 8'd1;
          end
        end
        IDLE: begin
          if (req_val && req_rdy) begin
            req_rdy <= 1'b0;
            op_q    <= req_op;
            adr_q   <= req_adr;
            tag_q   <= req_tag;
            way_q   <= req_way;
            case (req_op)
              OP_FILL: begin
                state      <= WR;
                dir_wr_en  <= 4'b0001 << req_way;
                dir_wr_adr <= req_adr;
                dir_wr_dat <= {4{1'b1, req_tag}};
              end
              OP_INVALL: begin
                state     <= SWEEP;
                cnt       <= 8'd0;
                busy      <= 1'b1;
                sweep_rsp <= 1'b1;
              end
              default: begin
                state      <= RD;
                dir_rd_adr <= req_adr;
              end
            endcase
          end
        end
        RD: state <= CMP;
        CMP: begin
          state     <= RSP;
          hit_q     <= |hit_vec;
          hit_way_q <= low_way;
          if (op_q == OP_INV) begin
            dir_wr_en  <= hit_vec;
            dir_wr_adr <= adr_q;
            dir_wr_dat <= 32'd0;
          end
        end
        WR: begin
          state     <= RSP;
          hit_q     <= 1'b0;
          hit_way_q <= way_q;
        end
        RSP: begin
          state   <= IDLE;
          req_rdy <= 1'b1;
          rsp_val <= 1'b1;
          rsp_op  <= op_q;
          rsp_hit <= (op_q == OP_LOOKUP || op_q == OP_INV) ? hit_q : 1'b0;
          rsp_way <= hit_way_q;
        end
        default: begin
          state   <= SWEEP;
          cnt     <= 8'd0;
          busy    <= 1'b1;
          req_rdy <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dir_ctl.sv
// tb/tb_dir_ctl.sv - randomized bench for dir_ctl against a transaction-level directory model
module tb_dir_ctl;

  localparam int ROWS = 128;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_val = 1'b0;
  logic        req_rdy;
  logic [1:0]  req_op = 2'd0;
  logic [6:0]  req_adr = 7'd0;
  logic [6:0]  req_tag = 7'd0;
  logic [1:0]  req_way = 2'd0;
  logic        rsp_val;
  logic [1:0]  rsp_op;
  logic        rsp_hit;
  logic [1:0]  rsp_way;
  logic        busy;
  logic [6:0]  dir_rd_adr;
  logic [31:0] dir_rd_dat = 32'd0;
  logic [3:0]  dir_wr_en;
  logic [6:0]  dir_wr_adr;
  logic [31:0] dir_wr_dat;

  dir_ctl #(.ROWS(ROWS), .WAYS(4)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_val(req_val), .req_rdy(req_rdy), .req_op(req_op), .req_adr(req_adr),
    .req_tag(req_tag), .req_way(req_way),
    .rsp_val(rsp_val), .rsp_op(rsp_op), .rsp_hit(rsp_hit), .rsp_way(rsp_way),
    .busy(busy),
    .dir_rd_adr(dir_rd_adr), .dir_rd_dat(dir_rd_dat),
    .dir_wr_en(dir_wr_en), .dir_wr_adr(dir_wr_adr), .dir_wr_dat(dir_wr_dat)
  );

  always #5 clk = ~clk;

  // directory RAM: byte-lane writes, registered one-cycle read
  logic [31:0] ram [0:ROWS-1];
  initial for (int r = 0; r < ROWS; r++) ram[r] = $urandom;
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (dir_wr_en[b]) ram[dir_wr_adr][8*b +: 8] <= dir_wr_dat[8*b +: 8];
    dir_rd_dat <= ram[dir_rd_adr];
  end

  // clock edges since reset release
  int cyc;
  always @(posedge clk or negedge rst_n)
    if (!rst_n) cyc <= 0; else cyc <= cyc + 1;

  typedef struct {
    int         due;
    logic [1:0] op;
    logic       hit;
    logic [1:0] way;
  } rsp_t;

  rsp_t       exp_q[$];
  logic [7:0] ref_b [0:ROWS-1][0:3];
  int         free_at;
  bit         sweep_pending;
  int         acc_edge;
  int         n_cmp = 0;
  int         n_bad = 0;
  logic [1:0] last_op;
  logic       last_hit;
  logic [1:0] last_way;
  int         last_rsp_cyc;
  logic [3:0] last_wr_en;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h (cyc %0d)", nm, act, exp, cyc);
    end
  endtask

  function automatic int ram_bad_rows();
    int bad = 0;
    for (int r = 0; r < ROWS; r++)
      if (ram[r] !== {ref_b[r][3], ref_b[r][2], ref_b[r][1], ref_b[r][0]}) bad++;
    return bad;
  endfunction

  task automatic model_clear();
    for (int r = 0; r < ROWS; r++)
      for (int w = 0; w < 4; w++) ref_b[r][w] = 8'h00;
  endtask

  // what the directory must do with one accepted request; edge = accepting clock edge
  task automatic model_accept(input logic [1:0] op, input logic [6:0] adr,
                              input logic [6:0] tag, input logic [1:0] way, input int edge_n);
    rsp_t e;
    int   first;
    first = -1;
    for (int w = 0; w < 4; w++)
      if (ref_b[adr][w][7] && ref_b[adr][w][6:0] == tag && first < 0) first = w;
    e.op  = op;
    e.hit = 1'b0;
    e.way = 2'd0;
    case (op)
      2'b00: begin e.due = edge_n + 3; e.hit = (first >= 0); e.way = (first >= 0) ? 2'(first) : 2'd0; end
      2'b01: begin e.due = edge_n + 2; e.way = way; ref_b[adr][way] = {1'b1, tag}; end
      2'b10: begin
        e.due = edge_n + 3; e.hit = (first >= 0); e.way = (first >= 0) ? 2'(first) : 2'd0;
        for (int w = 0; w < 4; w++)
          if (ref_b[adr][w][7] && ref_b[adr][w][6:0] == tag) ref_b[adr][w] = 8'h00;
      end
      default: begin e.due = edge_n + 1 + ROWS; model_clear(); end
    endcase
    sweep_pending = (op == 2'b11);
    free_at       = e.due;
    acc_edge      = edge_n;
    exp_q.push_back(e);
  endtask

  // per-cycle comparison of DUT outputs against the model schedule
  always @(negedge clk) begin
    if (rst_n) begin
      bit due;
      chk("req_rdy", req_rdy, cyc >= free_at);
      chk("busy", busy, (cyc < free_at) && sweep_pending);
      if (sweep_pending && cyc < free_at && cyc >= free_at - ROWS) begin
        chk("sweep_wr_en", dir_wr_en, 4'hF);
        chk("sweep_wr_adr", dir_wr_adr, cyc - (free_at - ROWS));
        chk("sweep_wr_dat", dir_wr_dat, 32'd0);
      end
      if (cyc >= free_at) chk("idle_wr_en", dir_wr_en, 4'd0);
      due = (exp_q.size() > 0) && (exp_q[0].due == cyc);
      chk("rsp_val", rsp_val, due);
      if (due) begin
        chk("rsp_op", rsp_op, exp_q[0].op);
        chk("rsp_hit", rsp_hit, exp_q[0].hit);
        chk("rsp_way", rsp_way, exp_q[0].way);
        last_op = rsp_op; last_hit = rsp_hit; last_way = rsp_way; last_rsp_cyc = cyc;
        void'(exp_q.pop_front());
      end
      if (cyc == free_at) chk("ram_rows_bad", ram_bad_rows(), 0);
      if (dir_wr_en != 4'd0 && !busy) last_wr_en = dir_wr_en;
    end
  end

  task automatic slot();
    @(negedge clk);
    #1;
  endtask

  task automatic do_req(input logic [1:0] op, input logic [6:0] adr,
                        input logic [6:0] tag, input logic [1:0] way);
    bit done = 0;
    slot();
    req_op = op; req_adr = adr; req_tag = tag; req_way = way; req_val = 1'b1;
    last_wr_en = 4'd0;
    for (int i = 0; i < 400 && !done; i++) begin
      if (req_rdy) begin
        model_accept(op, adr, tag, way, cyc + 1);
        done = 1;
      end else slot();
    end
    if (!done) chk("accept_timeout", 0, 1);
  endtask

  task automatic wait_idle();
    bit done = 0;
    for (int i = 0; i < 400 && !done; i++) begin
      slot();
      req_val = 1'b0;
      if (req_rdy) done = 1;
    end
    if (!done) chk("idle_timeout", 0, 1);
  endtask

  task automatic reset_model();
    exp_q.delete();
    model_clear();
    free_at = ROWS + 1;
    sweep_pending = 1;
  endtask

  task automatic check_reset_outputs();
    chk("rst_req_rdy", req_rdy, 0);
    chk("rst_busy", busy, 1);
    chk("rst_rsp_val", rsp_val, 0);
    chk("rst_wr_en", dir_wr_en, 0);
    chk("rst_rd_adr", dir_rd_adr, 0);
    chk("rst_wr_adr", dir_wr_adr, 0);
  endtask

  task automatic release_and_sweep();
    rst_n = 1'b1;
    slot();
    chk("sweep_first_adr", dir_wr_adr, 0);
    chk("sweep_first_en", dir_wr_en, 4'hF);
    wait_idle();
    chk("rdy_cycle", cyc, ROWS + 1);
  endtask

  initial begin
    bit found;
    int row;
    reset_model();
    repeat (3) slot();
    check_reset_outputs();
    release_and_sweep();

    // first lookup after the clear misses
    do_req(2'b00, 7'd33, 7'd5, 2'd0); wait_idle();
    chk("first_lookup_hit", last_hit, 0);

    // fill then lookup
    do_req(2'b01, 7'd5, 7'h3A, 2'd2); wait_idle();
    chk("fill_wr_en", last_wr_en, 4'b0100);
    chk("fill_lane2", ram[5][23:16], 8'hBA);
    chk("fill_latency", last_rsp_cyc - acc_edge, 2);
    do_req(2'b00, 7'd5, 7'h3A, 2'd0); wait_idle();
    chk("lookup_hit", last_hit, 1);
    chk("lookup_way", last_way, 2);
    chk("lookup_latency", last_rsp_cyc - acc_edge, 3);

    // two ways with the same tag, invalidate clears both; back-to-back requests
    do_req(2'b01, 7'd9, 7'h11, 2'd1);
    do_req(2'b01, 7'd9, 7'h11, 2'd3);
    do_req(2'b10, 7'd9, 7'h11, 2'd0); wait_idle();
    chk("inv_wr_en", last_wr_en, 4'b1010);
    chk("inv_hit", last_hit, 1);
    chk("inv_way", last_way, 1);
    do_req(2'b00, 7'd9, 7'h11, 2'd0); wait_idle();
    chk("post_inv_hit", last_hit, 0);

    // invalidate with no match writes nothing
    do_req(2'b10, 7'd7, 7'h22, 2'd0); wait_idle();
    chk("inv_miss_wr_en", last_wr_en, 4'd0);
    chk("inv_miss_hit", last_hit, 0);
    chk("inv_miss_op", last_op, 2'b10);

    // randomized traffic, sometimes held across busy periods
    for (int n = 0; n < 250; n++) begin
      int r;
      logic [1:0] op;
      r  = $urandom_range(0, 99);
      op = (r < 40) ? 2'b00 : (r < 70) ? 2'b01 : (r < 98) ? 2'b10 : 2'b11;
      row = ($urandom_range(0, 3) == 0) ? $urandom_range(0, ROWS - 1) : $urandom_range(0, 7);
      do_req(op, 7'(row), 7'($urandom_range(0, 3)), 2'($urandom_range(0, 3)));
      if ($urandom_range(0, 1) == 1) begin
        repeat ($urandom_range(1, 4)) begin slot(); req_val = 1'b0; end
      end
    end
    wait_idle();

    // invalidate-all interrupted by reset at row 60
    do_req(2'b01, 7'd100, 7'h07, 2'd0);
    do_req(2'b01, 7'd3, 7'h01, 2'd3);
    do_req(2'b11, 7'd0, 7'd0, 2'd0);
    found = 0;
    for (int i = 0; i < 300 && !found; i++) begin
      slot();
      req_val = 1'b0;
      if (dir_wr_en == 4'hF && dir_wr_adr == 7'd60) found = 1;
    end
    chk("reached_row60", found, 1);
    rst_n = 1'b0;
    reset_model();
    repeat (2) slot();
    check_reset_outputs();
    release_and_sweep();
    chk("row100_cleared", ram[100], 32'd0);
    do_req(2'b00, 7'd100, 7'h07, 2'd0); wait_idle();
    chk("row100_lookup_hit", last_hit, 0);
    do_req(2'b00, 7'd3, 7'h01, 2'd0); wait_idle();
    chk("row3_lookup_hit", last_hit, 0);

    repeat (3) slot();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
